// File: rtl/tl_a_arbiter_2to1_if.sv
// TileLink-UL A/D port bundle (32-bit address, 32-bit data).
// SRC_W sets the source-ID width: 2 on the client ports, 3 on the shared port.
//   master : drives A (valid + bits) and d_ready; samples a_ready and D.
//   slave  : drives a_ready and D (valid + bits); samples A and d_ready.
interface tl_a_arbiter_2to1_if #(
    parameter int unsigned SRC_W = 2
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = DATA_W / 8;

    logic              a_ready;
    logic              a_valid;
    logic [2:0]        a_bits_opcode;
    logic [2:0]        a_bits_param;
    logic [2:0]        a_bits_size;
    logic [SRC_W-1:0]  a_bits_source;
    logic [ADDR_W-1:0] a_bits_address;
    logic [MASK_W-1:0] a_bits_mask;
    logic [DATA_W-1:0] a_bits_data;
    logic              a_bits_corrupt;

    logic              d_ready;
    logic              d_valid;
    logic [2:0]        d_bits_opcode;
    logic [2:0]        d_bits_size;
    logic [SRC_W-1:0]  d_bits_source;
    logic              d_bits_denied;
    logic              d_bits_corrupt;
    logic [DATA_W-1:0] d_bits_data;

    modport master (
        input  a_ready,
        output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
        output d_ready,
        input  d_valid, d_bits_opcode, d_bits_size, d_bits_source,
               d_bits_denied, d_bits_corrupt, d_bits_data
    );

    modport slave (
        output a_ready,
        input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
               a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
        input  d_ready,
        output d_valid, d_bits_opcode, d_bits_size, d_bits_source,
               d_bits_denied, d_bits_corrupt, d_bits_data
    );
endinterface

// File: rtl/tl_a_arbiter_2to1.sv
// Two-client TileLink-UL arbiter sharing one downstream A/D port.
// A channel: round-robin between clients, locked for a whole multi-beat message
// and from the first presented beat of a stalled message; source is tagged
// {client, client_source}. D channel: steered back by the tag bit, stateless.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   in0, in1     : client ports (slave side, 2-bit source)
//   out          : shared downstream port (master side, 3-bit source)
module tl_a_arbiter_2to1 #(
    parameter int unsigned MAX_LG_SIZE   = 6,
    parameter int unsigned BEAT_BYTES_LG = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    tl_a_arbiter_2to1_if.slave   in0,
    tl_a_arbiter_2to1_if.slave   in1,
    tl_a_arbiter_2to1_if.master  out
);
    localparam int unsigned BEATS_W = MAX_LG_SIZE - BEAT_BYTES_LG + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    logic [1:0]         r_state;
    logic               r_grant;
    logic               r_prio;
    logic [BEATS_W-1:0] r_beats_left;

    logic [1:0]         w_state_nxt;
    logic               w_grant_nxt;
    logic               w_prio_nxt;
    logic [BEATS_W-1:0] w_beats_nxt;

    logic [1:0]         w_valid;
    logic               w_sel;
    logic               w_fire;
    logic [2:0]         w_opcode;
    logic [2:0]         w_size;
    logic [BEATS_W-1:0] w_beats;
    logic               w_d_sel;

    // Beats in a message: data-bearing opcodes (0..3) span size/bus-width beats.
    function automatic logic [BEATS_W-1:0] f_beats(input logic [2:0] opcode,
                                                   input logic [2:0] size);
        if (opcode <= 3'd3 && size > 3'(BEAT_BYTES_LG))
            f_beats = BEATS_W'(1) << (size - 3'(BEAT_BYTES_LG));
        else
            f_beats = BEATS_W'(1);
    endfunction

    assign w_valid = {in1.a_valid, in0.a_valid};

    // Source select: preferred-then-other when idle, locked to grant otherwise.
    always_comb begin
        w_sel = r_grant;
        if (r_state == ST_IDLE) begin
            w_sel = r_prio;
            if (!w_valid[r_prio] && w_valid[~r_prio])
                w_sel = ~r_prio;
        end
    end

    // A mux; valid and readies are held low during reset.
    assign w_opcode              = w_sel ? in1.a_bits_opcode : in0.a_bits_opcode;
    assign w_size                = w_sel ? in1.a_bits_size   : in0.a_bits_size;
    assign out.a_valid           = w_valid[w_sel] & ~reset;
    assign out.a_bits_opcode     = w_opcode;
    assign out.a_bits_param      = w_sel ? in1.a_bits_param   : in0.a_bits_param;
    assign out.a_bits_size       = w_size;
    assign out.a_bits_source     = {w_sel, (w_sel ? in1.a_bits_source : in0.a_bits_source)};
    assign out.a_bits_address    = w_sel ? in1.a_bits_address : in0.a_bits_address;
    assign out.a_bits_mask       = w_sel ? in1.a_bits_mask    : in0.a_bits_mask;
    assign out.a_bits_data       = w_sel ? in1.a_bits_data    : in0.a_bits_data;
    assign out.a_bits_corrupt    = w_sel ? in1.a_bits_corrupt : in0.a_bits_corrupt;
    assign in0.a_ready           = out.a_ready & ~w_sel & ~reset;
    assign in1.a_ready           = out.a_ready &  w_sel & ~reset;

    assign w_fire  = out.a_valid & out.a_ready;
    assign w_beats = f_beats(w_opcode, w_size);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_prio       <= 1'b0;
            r_beats_left <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_prio       <= w_prio_nxt;
            r_beats_left <= w_beats_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_prio_nxt  = r_prio;
        w_beats_nxt = r_beats_left;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (w_fire) begin
                    if (w_beats <= BEATS_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_prio_nxt  = ~w_sel;
                    end else begin
                        w_state_nxt = ST_BURST;
                        w_grant_nxt = w_sel;
                        w_beats_nxt = w_beats - BEATS_W'(1);
                    end
                end else if (w_valid[w_sel]) begin
                    // Presented but not accepted: pin the source until it fires.
                    w_state_nxt = ST_HOLD;
                    w_grant_nxt = w_sel;
                end
            end
            ST_BURST: begin
                if (w_fire) begin
                    w_beats_nxt = r_beats_left - BEATS_W'(1);
                    if (r_beats_left == BEATS_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_prio_nxt  = ~r_grant;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // D routing by the client tag in the response source.
    assign w_d_sel            = out.d_bits_source[2];
    assign in0.d_valid        = out.d_valid & ~w_d_sel & ~reset;
    assign in1.d_valid        = out.d_valid &  w_d_sel & ~reset;
    assign out.d_ready        = (w_d_sel ? in1.d_ready : in0.d_ready) & ~reset;
    assign in0.d_bits_source  = out.d_bits_source[1:0];
    assign in1.d_bits_source  = out.d_bits_source[1:0];
    assign in0.d_bits_opcode  = out.d_bits_opcode;
    assign in1.d_bits_opcode  = out.d_bits_opcode;
    assign in0.d_bits_size    = out.d_bits_size;
    assign in1.d_bits_size    = out.d_bits_size;
    assign in0.d_bits_denied  = out.d_bits_denied;
    assign in1.d_bits_denied  = out.d_bits_denied;
    assign in0.d_bits_corrupt = out.d_bits_corrupt;
    assign in1.d_bits_corrupt = out.d_bits_corrupt;
    assign in0.d_bits_data    = out.d_bits_data;
    assign in1.d_bits_data    = out.d_bits_data;
endmodule

// File: tb/tb_tl_a_arbiter_2to1.sv
// Testbench for tl_a_arbiter_2to1: directed scenarios plus a randomized run
// checked against a message-level arbitration model.
module tb_tl_a_arbiter_2to1;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tl_a_arbiter_2to1_if #(.SRC_W(2)) in0_if ();
    tl_a_arbiter_2to1_if #(.SRC_W(2)) in1_if ();
    tl_a_arbiter_2to1_if #(.SRC_W(3)) out_if ();

    tl_a_arbiter_2to1 dut (
        .clock (clk),
        .reset (rst),
        .in0   (in0_if),
        .in1   (in1_if),
        .out   (out_if)
    );

    task automatic drive_a(input int c, input logic v, input logic [2:0] op,
                           input logic [2:0] size, input logic [1:0] src,
                           input logic [31:0] addr, input logic [31:0] data);
        if (c == 0) begin
            in0_if.a_valid = v; in0_if.a_bits_opcode = op; in0_if.a_bits_param = 3'd0;
            in0_if.a_bits_size = size; in0_if.a_bits_source = src; in0_if.a_bits_address = addr;
            in0_if.a_bits_mask = 4'hF; in0_if.a_bits_data = data; in0_if.a_bits_corrupt = 1'b0;
        end else begin
            in1_if.a_valid = v; in1_if.a_bits_opcode = op; in1_if.a_bits_param = 3'd0;
            in1_if.a_bits_size = size; in1_if.a_bits_source = src; in1_if.a_bits_address = addr;
            in1_if.a_bits_mask = 4'hF; in1_if.a_bits_data = data; in1_if.a_bits_corrupt = 1'b0;
        end
    endtask

    task automatic idle_all();
        drive_a(0, 1'b0, 3'd4, 3'd2, 2'd0, 32'h0, 32'h0);
        drive_a(1, 1'b0, 3'd4, 3'd2, 2'd0, 32'h0, 32'h0);
        out_if.a_ready = 1'b0;
        out_if.d_valid = 1'b0; out_if.d_bits_opcode = 3'd1; out_if.d_bits_size = 3'd2;
        out_if.d_bits_source = 3'd0; out_if.d_bits_denied = 1'b0; out_if.d_bits_corrupt = 1'b0;
        out_if.d_bits_data = 32'h0;
        in0_if.d_ready = 1'b0; in1_if.d_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_all();
        drive_a(0, 1'b1, 3'd4, 3'd2, 2'd0, 32'h10, 32'h0);
        drive_a(1, 1'b1, 3'd4, 3'd2, 2'd1, 32'h20, 32'h0);
        out_if.a_ready = 1'b1; out_if.d_valid = 1'b1; out_if.d_bits_source = 3'b100;
        in0_if.d_ready = 1'b1; in1_if.d_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({out_if.a_valid, in0_if.a_ready, in1_if.a_ready, in0_if.d_valid, in1_if.d_valid,
             out_if.d_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000", {out_if.a_valid, in0_if.a_ready,
                     in1_if.a_ready, in0_if.d_valid, in1_if.d_valid, out_if.d_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        idle_all();
    endtask

    task automatic test_single_get();
        @(negedge clk);
        idle_all();
        drive_a(1, 1'b1, 3'd4, 3'd2, 2'd2, 32'h1000, 32'h0);
        out_if.a_ready = 1'b1;
        #1;
        checks++;
        if ({out_if.a_valid, out_if.a_bits_source, in1_if.a_ready, in0_if.a_ready} !== 6'b1_110_10) begin
            errors++;
            $display("FAIL single_get_hs: got %b want 111010",
                     {out_if.a_valid, out_if.a_bits_source, in1_if.a_ready, in0_if.a_ready});
        end
        checks++;
        if (out_if.a_bits_address !== 32'h1000) begin
            errors++;
            $display("FAIL single_get_addr: got %h want 00001000", out_if.a_bits_address);
        end
    endtask

    // Both clients request 1-beat Gets continuously; preference must alternate.
    task automatic test_alternate();
        logic exp;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_a(0, 1'b1, 3'd4, 3'd2, 2'd0, 32'h100 + 32'(k), 32'h0);
            drive_a(1, 1'b1, 3'd4, 3'd2, 2'd1, 32'h200 + 32'(k), 32'h0);
            out_if.a_ready = 1'b1;
            #1;
            exp = 1'(k % 2);
            checks++;
            if ({out_if.a_bits_source[2], in0_if.a_ready, in1_if.a_ready} !== {exp, ~exp, exp}) begin
                errors++;
                $display("FAIL alternate[%0d]: got %b want %b", k,
                         {out_if.a_bits_source[2], in0_if.a_ready, in1_if.a_ready}, {exp, ~exp, exp});
            end
        end
    endtask

    // 4-beat PutFull from client 0 with client 1 waiting and a stalling slave.
    task automatic test_burst();
        bit seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int c0 = 0;
        bit done = 1'b0;
        for (int cyc = 0; cyc < 12 && !done; cyc++) begin
            @(negedge clk);
            drive_a(0, c0 < 4, 3'd0, 3'd4, 2'd3, 32'h2000, $urandom);
            drive_a(1, 1'b1, 3'd4, 3'd2, 2'd0, 32'h3000, 32'h0);
            out_if.a_ready = (cyc < 5) ? seq[cyc] : 1'b1;
            #1;
            if (c0 < 4) begin
                checks++;
                if ({in1_if.a_ready, out_if.a_bits_source} !== 4'b0_011) begin
                    errors++;
                    $display("FAIL burst_lock[%0d]: got %b want 0011", cyc,
                             {in1_if.a_ready, out_if.a_bits_source});
                end
            end
            if (in1_if.a_ready && in1_if.a_valid) begin
                done = 1'b1;
                checks++;
                if (c0 !== 4) begin
                    errors++;
                    $display("FAIL burst_count: got %0d client-0 beats want 4", c0);
                end
            end
            if (in0_if.a_ready && in0_if.a_valid) c0++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL burst_timeout: client 1 never granted, got 0 want 1");
        end
    endtask

    // Stalled client-0 message must keep the grant even after client 1 (preferred) asks.
    task automatic test_hold();
        @(negedge clk);
        idle_all();
        drive_a(0, 1'b1, 3'd4, 3'd2, 2'd0, 32'h3F00, 32'h0);
        out_if.a_ready = 1'b1;  // client 0 fires alone -> client 1 preferred
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_a(0, 1'b1, 3'd4, 3'd2, 2'd2, 32'h4000, 32'h0);
            drive_a(1, k > 0, 3'd4, 3'd2, 2'd1, 32'h5000, 32'h0);
            out_if.a_ready = (k == 3);
            #1;
            checks++;
            if ({out_if.a_valid, out_if.a_bits_source, in0_if.a_ready, in1_if.a_ready} !==
                {1'b1, 3'b010, (k == 3), 1'b0}) begin
                errors++;
                $display("FAIL hold[%0d]: got %b want %b", k,
                         {out_if.a_valid, out_if.a_bits_source, in0_if.a_ready, in1_if.a_ready},
                         {1'b1, 3'b010, (k == 3), 1'b0});
            end
        end
        @(negedge clk);
        drive_a(0, 1'b0, 3'd4, 3'd2, 2'd0, 32'h0, 32'h0);
        #1;
        checks++;
        if ({out_if.a_bits_source, in1_if.a_ready} !== 4'b101_1) begin
            errors++;
            $display("FAIL hold_release: got %b want 1011", {out_if.a_bits_source, in1_if.a_ready});
        end
        @(negedge clk);
        idle_all();
    endtask

    task automatic test_d_route();
        @(negedge clk);
        out_if.d_valid = 1'b1; out_if.d_bits_source = 3'b101; out_if.d_bits_data = 32'hCAFEF00D;
        in0_if.d_ready = 1'b1; in1_if.d_ready = 1'b0;
        #1;
        checks++;
        if ({in1_if.d_valid, in1_if.d_bits_source, in0_if.d_valid, out_if.d_ready} !== 5'b1_01_0_0) begin
            errors++;
            $display("FAIL d_route_c1: got %b want 10100",
                     {in1_if.d_valid, in1_if.d_bits_source, in0_if.d_valid, out_if.d_ready});
        end
        checks++;
        if (in0_if.d_bits_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL d_broadcast: got %h want cafef00d", in0_if.d_bits_data);
        end
        in1_if.d_ready = 1'b1;
        #1;
        checks++;
        if (out_if.d_ready !== 1'b1) begin
            errors++;
            $display("FAIL d_ready_c1: got %b want 1", out_if.d_ready);
        end
        out_if.d_bits_source = 3'b010; in0_if.d_ready = 1'b0;
        #1;
        checks++;
        if ({in0_if.d_valid, in0_if.d_bits_source, in1_if.d_valid, out_if.d_ready} !== 5'b1_10_0_0) begin
            errors++;
            $display("FAIL d_route_c0: got %b want 11000",
                     {in0_if.d_valid, in0_if.d_bits_source, in1_if.d_valid, out_if.d_ready});
        end
        out_if.d_valid = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        idle_all();
        drive_a(0, 1'b1, 3'd4, 3'd2, 2'd0, 32'h4400, 32'h0);
        out_if.a_ready = 1'b1;  // client 0 single fire -> client 1 preferred
        @(negedge clk);
        drive_a(0, 1'b1, 3'd0, 3'd4, 2'd1, 32'h5000, 32'h1);  // beat 1 fires
        @(negedge clk);
        drive_a(0, 1'b1, 3'd0, 3'd4, 2'd1, 32'h5000, 32'h2);
        drive_a(1, 1'b1, 3'd4, 3'd2, 2'd3, 32'h6000, 32'h0);
        out_if.a_ready = 1'b0;
        out_if.d_valid = 1'b1; out_if.d_bits_source = 3'b000; in0_if.d_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_if.a_valid, in0_if.a_ready, in1_if.a_ready, in0_if.d_valid, in1_if.d_valid,
             out_if.d_ready} !== 6'b0) begin
            errors++;
            $display("FAIL midburst_reset: got %b want 000000", {out_if.a_valid, in0_if.a_ready,
                     in1_if.a_ready, in0_if.d_valid, in1_if.d_valid, out_if.d_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        out_if.d_valid = 1'b0;
        drive_a(0, 1'b1, 3'd4, 3'd2, 2'd1, 32'h7000, 32'h0);
        out_if.a_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (out_if.a_bits_source[2] !== 1'(k)) begin
                errors++;
                $display("FAIL post_reset_grant[%0d]: got %b want %0d", k, out_if.a_bits_source[2], k);
            end
        end
        @(negedge clk);
        idle_all();
    endtask

    function automatic int msg_beats(input logic [2:0] op, input logic [2:0] sz);
        int s = int'(sz);
        if (op <= 3'd3 && s > 2) return 1 << (s - 2);
        return 1;
    endfunction

    // Random traffic vs. a message-level model: a message owns the port from its
    // first presented beat until its last beat fires; completion flips preference.
    task automatic test_random();
        logic        act [2];
        logic        v   [2];
        logic [2:0]  op  [2];
        logic [2:0]  sz  [2];
        logic [1:0]  src [2];
        logic [31:0] addr[2];
        int          left[2];
        int          sent[2];
        int          owner = -1;
        int          pref  = 0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; v[i] = 1'b0; left[i] = 0; sent[i] = 0;
            op[i] = 3'd4; sz[i] = 3'd2; src[i] = 2'd0; addr[i] = 32'h0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            int          w;
            logic        wv;
            logic        fire;
            logic        dc;
            logic        dv, r0, r1;
            logic [2:0]  dsrc;
            logic [31:0] ddata;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!act[i]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        act[i] = 1'b1; sent[i] = 0;
                        op[i] = 3'($urandom_range(5, 0)); sz[i] = 3'($urandom_range(6, 0));
                        src[i] = 2'($urandom); addr[i] = $urandom;
                        left[i] = msg_beats(op[i], sz[i]);
                        v[i] = 1'b1;
                    end
                end else if (sent[i] > 0) begin
                    v[i] = ($urandom_range(3, 0) != 0);
                end
                drive_a(i, v[i], op[i], sz[i], src[i], addr[i], $urandom);
            end
            out_if.a_ready = ($urandom_range(3, 0) != 0);
            dv = 1'($urandom); dsrc = 3'($urandom); ddata = $urandom;
            r0 = 1'($urandom); r1 = 1'($urandom);
            out_if.d_valid = dv; out_if.d_bits_source = dsrc; out_if.d_bits_data = ddata;
            in0_if.d_ready = r0; in1_if.d_ready = r1;
            #1;
            if (owner >= 0) w = owner;
            else if (v[pref]) w = pref;
            else if (v[1 - pref]) w = 1 - pref;
            else w = -1;
            wv = (w >= 0) ? v[w] : 1'b0;
            checks++;
            if (out_if.a_valid !== wv) begin
                errors++;
                $display("FAIL rand_a_valid[%0d]: got %b want %b", cyc, out_if.a_valid, wv);
            end
            if (w >= 0) begin
                checks++;
                if ({in0_if.a_ready, in1_if.a_ready} !==
                    {(w == 0) & out_if.a_ready, (w == 1) & out_if.a_ready}) begin
                    errors++;
                    $display("FAIL rand_a_ready[%0d]: got %b%b want owner %0d", cyc,
                             in0_if.a_ready, in1_if.a_ready, w);
                end
                if (wv) begin
                    checks++;
                    if ({out_if.a_bits_source, out_if.a_bits_address, out_if.a_bits_opcode,
                         out_if.a_bits_size} !== {1'(w), src[w], addr[w], op[w], sz[w]}) begin
                        errors++;
                        $display("FAIL rand_a_bits[%0d]: got src %b addr %h want src %b addr %h",
                                 cyc, out_if.a_bits_source, out_if.a_bits_address,
                                 {1'(w), src[w]}, addr[w]);
                    end
                end
            end
            dc = dsrc[2];
            checks++;
            if ({in0_if.d_valid, in1_if.d_valid, out_if.d_ready, in0_if.d_bits_source,
                 in1_if.d_bits_data} !== {dv & ~dc, dv & dc, dc ? r1 : r0, dsrc[1:0], ddata}) begin
                errors++;
                $display("FAIL rand_d[%0d]: got %b%b%b want %b%b%b", cyc, in0_if.d_valid,
                         in1_if.d_valid, out_if.d_ready, dv & ~dc, dv & dc, dc ? r1 : r0);
            end
            fire = wv & out_if.a_ready;
            if (w >= 0 && wv && owner < 0) owner = w;
            if (fire) begin
                left[w]--; sent[w]++;
                if (left[w] == 0) begin
                    pref = 1 - w; owner = -1; act[w] = 1'b0; v[w] = 1'b0;
                end
            end
        end
        @(negedge clk);
        idle_all();
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_get();
        test_alternate();
        test_burst();
        test_hold();
        test_d_route();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tl_a_arbiter_2to1.md
Name: tl_a_arbiter_2to1

Overview:
- Two-client TileLink-UL arbiter (32-bit data, 32-bit address) that shares one downstream A/D port between two masters.
- Sits between two width-widget/buffer stages and the shared slave port.
- Arbitrates the A channel round-robin with burst locking, and tags the upstream source ID with the client index.
- Routes D-channel responses back to the owning client by that tag.

Parameters:
- MAX_LG_SIZE, 6: largest legal lg2(bytes) of a message; sets beat counter width (16 beats max at 32-bit data).
- BEAT_BYTES_LG, 2: lg2 of data bus bytes (fixed at 4 B).

Ports:
- clock  input  1  sole clock
- reset  input  1  asynchronous, active-high
- in0_a_ready  output  1  client 0 A accept
- in0_a_valid  input  1  client 0 A valid
- in0_a_bits_opcode / _param / _size  input  3 each  A fields
- in0_a_bits_source  input  2  client-local source ID
- in0_a_bits_address  input  32;  in0_a_bits_mask  input  4;  in0_a_bits_data  input  32;  in0_a_bits_corrupt  input  1
- in0_d_ready  input  1;  in0_d_valid  output  1
- in0_d_bits_opcode / _size  output  3 each;  in0_d_bits_source  output  2
- in0_d_bits_denied / _corrupt  output  1 each;  in0_d_bits_data  output  32
- in1_*  same set, widths and directions as in0_*, for client 1
- out_a_ready  input  1;  out_a_valid  output  1
- out_a_bits_opcode / _param / _size  output  3 each
- out_a_bits_source  output  3  {client index, client source}
- out_a_bits_address  output  32;  out_a_bits_mask  output  4;  out_a_bits_data  output  32;  out_a_bits_corrupt  output  1
- out_d_ready  output  1;  out_d_valid  input  1
- out_d_bits_opcode / _size  input  3 each;  out_d_bits_source  input  3
- out_d_bits_denied / _corrupt  input  1 each;  out_d_bits_data  input  32

Behaviour:
- **Registers:**
  - state ∈ {IDLE, HOLD, BURST}
  - grant (1 bit)
  - prio (1 bit, client preferred next)
  - beats_left (log2(2^MAX_LG_SIZE/4)+1 bits)
- **Reset (async):** state=IDLE, grant=0, prio=0, beats_left=0. While reset is high: out_a_valid=0, in0/in1_a_ready=0, in0/in1_d_valid=0, out_d_ready=0.
- **Beat count:**
  - Data-bearing opcodes (0 PutFull, 1 PutPartial, 2 Arithmetic, 3 Logical) → beats = 2^(size-2) if size>2, else 1.
  - Other opcodes (4 Get, 5 Hint) → 1 beat.
- **IDLE:**
  - Winner = prio if in[prio]_a_valid, else the other client if valid.
  - The winner's A fields go out combinationally (0-cycle latency). out_a_valid = winner valid; in[winner]_a_ready = out_a_ready; loser ready = 0.
  - out_a_bits_source = {winner, in[winner]_a_bits_source}.
  - Fire of a 1-beat message: stay IDLE, prio = ~winner.
  - Fire of an N>1 beat message: grant=winner, beats_left=N-1, go to BURST.
  - Valid presented without fire: grant=winner, go to HOLD.
- **HOLD:**
  - Mux locked to grant; the other client's valid is ignored even if it has priority. The presented beat must not change source.
  - On fire, same transitions as in IDLE, using grant.
- **BURST:**
  - Mux locked to grant; loser ready = 0.
  - Each fire decrements beats_left. The fire at beats_left==1 → IDLE, prio = ~grant.
  - Granted client deasserting valid mid-burst only stalls; no switch.
- **Simultaneous requests in IDLE:** prio wins. Each completed message toggles preference, so with both clients requesting continuously, message ownership alternates 0,1,0,1.
- **D routing (purely combinational, no state):**
  - c = out_d_bits_source[2]. in[c]_d_valid = out_d_valid; other client d_valid = 0.
  - out_d_ready = in[c]_d_ready.
  - in[c]_d_bits_source = out_d_bits_source[1:0].
  - All other D fields are broadcast to both clients.
- **A/D independence:** A and D are independent; D traffic never affects A state.
- **Reset mid-burst:** abandons the burst; post-reset state is as at reset.

Test Plan:
- Single Get from client 1 (size 2, source 2, addr 0x1000), out_a_ready=1 → same cycle out_a_valid=1, out_a_bits_source=3'b110, in1_a_ready=1; state stays IDLE, prio=0.
- Both clients valid with 1-beat Gets, out_a_ready=1 for 4 cycles → grants 0,1,0,1; each client sees ready only on its own grant cycle.
- Client 0 PutFull size 4 (4 beats) with client 1 valid throughout, out_a_ready toggling 1,0,1,1,1 → exactly 4 client-0 fires before any client-1 fire; in1_a_ready=0 throughout.
- HOLD: prio=1, only client 0 valid, out_a_ready=0; client 1 raises valid the next cycle → out_a_bits_source stays {0,x} until fire; then client 1 is granted.
- D response with out_d_bits_source=3'b101, out_d_valid=1, in1_d_ready=0 → in1_d_valid=1, in1_d_bits_source=2'b01, in0_d_valid=0, out_d_ready=0.
- Assert reset during beat 2 of a 4-beat Put → outputs and readies drop immediately (async); after release, state=IDLE and client 0 has priority.
